multi_cycle_controller: RTL and testbench

Sequencing FSM for the multi-cycle RISC-V datapath variant that shares one unified instruction/data memory. It decodes `op`/`func3` from the instruction register and steps the datapath through fetch, decode, execute, memory and writeback. It drives every datapath select and strobe. It also runs a ready/request handshake with a variable-latency memory and applies a wait-cycle timeout.

---
 rtl/multi_cycle_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// Sequencing FSM for the multi-cycle RISC-V datapath with a unified memory.
// Decodes op/func3 and steps the datapath through fetch, decode, execute,
// memory and writeback. It runs a ready/request handshake with a
// variable-latency memory and abandons or retries an access after a wait timeout.
module multi_cycle_controller #(
  parameter int unsigned WAIT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] immSrc,
  output logic       retire,
  output logic       illegal,
  output logic       busErr,
  output logic [3:0] state
);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpS    = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpJalr = 7'b1100111;

  // Counter value at the start of the wait cycle that brings the run to 2^WAIT_W-1.
  localparam int unsigned           WaitLastInt = (1 << WAIT_W) - 2;
  localparam logic [WAIT_W-1:0]     WaitLast    = WAIT_W'(WaitLastInt);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJalr     = 4'd10,
    StJal      = 4'd11,
    StLui      = 4'd12
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic       retire_c, illegal_c, timeout, mem_wait, taken;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;

  // State and wait-counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Branch condition from func3; unlisted encodings never take the branch.
  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b010:  taken = neg;
      3'b011:  taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

  // Next-state, datapath controls and memory wait/timeout handling.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    retire_c   = 1'b0;
    illegal_c  = 1'b0;
    mem_wait   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 3'b000;

    case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (memReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else begin
          mem_wait = 1'b1;
        end
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (op == OpB)        imm_src = 3'b010;
        else if (op == OpJal) imm_src = 3'b011;
        case (op)
          OpLw, OpS: state_d = StMemAdr;
          OpR:       state_d = StExecR;
          OpI:       state_d = StExecI;
          OpB:       state_d = StBranch;
          OpJal:     state_d = StJal;
          OpJalr:    state_d = StJalr;
          OpLui:     state_d = StLui;
          default: begin
            illegal_c = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OpS) ? 3'b001 : 3'b000;
        state_d   = (op == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (memReady) state_d = StMemWb;
        else          mem_wait = 1'b1;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire_c   = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (memReady) begin
          retire_c = 1'b1;
          state_d  = StFetch;
        end else begin
          mem_wait = 1'b1;
        end
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retire_c  = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = taken;
        retire_c  = 1'b1;
        state_d   = StFetch;
      end
      StJalr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = StJal;
      end
      StJal: begin
        // PC takes the target in ALUOut while the ALU forms the link OldPC+4.
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = StAluWb;
      end
      StLui: begin
        imm_src    = 3'b100;
        result_src = 2'b11;
        reg_write  = 1'b1;
        retire_c   = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // A ready memory never counts as waiting, so completion beats timeout.
    timeout = mem_wait && (wait_q == WaitLast);
    if (timeout) state_d = StFetch;

    if (!mem_wait || timeout || (state_d != state_q)) wait_d = '0;
    else                                              wait_d = wait_q + 1'b1;
  end

  // Reset forces every strobe and select low, dropping any in-flight access.
  assign memReq    = rst & mem_req;
  assign memWrite  = rst & mem_write;
  assign adrSrc    = rst & adr_src;
  assign irWrite   = rst & ir_write;
  assign pcWrite   = rst & pc_write;
  assign regWrite  = rst & reg_write;
  assign retire    = rst & retire_c;
  assign illegal   = rst & illegal_c;
  assign busErr    = rst & timeout;
  assign resultSrc = rst ? result_src : 2'b00;
  assign ALUSrcA   = rst ? alu_src_a : 2'b00;
  assign ALUSrcB   = rst ? alu_src_b : 2'b00;
  assign ALUOp     = rst ? alu_op : 2'b00;
  assign immSrc    = rst ? imm_src : 3'b000;
  assign state     = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: an instruction-level model
// expands each instruction into the expected per-cycle controls; a monitor
// compares them with the DUT outputs on the falling edge.
module tb_multi_cycle_controller;

  localparam int unsigned WaitW   = 4;
  localparam int          WaitMax = (1 << WaitW) - 1;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpS    = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpJalr = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst, zero, neg, memReady;
  logic [6:0] op;
  logic [2:0] func3;
  logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, retire, illegal, busErr;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] immSrc;
  logic [3:0] state;

  multi_cycle_controller #(.WAIT_W(WaitW)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .func3     (func3),
    .zero      (zero),
    .neg       (neg),
    .memReady  (memReady),
    .memReq    (memReq),
    .memWrite  (memWrite),
    .adrSrc    (adrSrc),
    .irWrite   (irWrite),
    .pcWrite   (pcWrite),
    .regWrite  (regWrite),
    .resultSrc (resultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .immSrc    (immSrc),
    .retire    (retire),
    .illegal   (illegal),
    .busErr    (busErr),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, mwr, adr, irw, pcw, rw, ret, ill, berr;
    logic [1:0] rsrc, asa, asb, aop;
    logic [2:0] imm;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  rec_t mon_e, mon_g;

  // Monitor: every cycle the DUT presents its controls, check against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_g = {state, memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, retire, illegal,
               busErr, resultSrc, ALUSrcA, ALUSrcB, ALUOp, immSrc};
      total++;
      if (mon_g !== mon_e) begin
        bad++;
        $display("FAIL trace t=%0t op=%b f3=%b: got %h want %h", $time, op, func3, mon_g, mon_e);
      end
    end
  end

  function automatic rec_t idle_rec(input logic [3:0] st);
    rec_t r;
    r    = '0;
    r.st = st;
    return r;
  endfunction

  function automatic bit known_op(input logic [6:0] o);
    return o inside {OpR, OpI, OpS, OpB, OpLui, OpJal, OpLw, OpJalr};
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd2:    return n;
      3'd3:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: apply memReady, queue the expected controls, advance.
  task automatic step(input rec_t e, input logic rdy);
    memReady = rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step_any(input rec_t e);
    step(e, 1'($urandom));
  endtask

  task automatic alu_wb();
    rec_t r;
    r     = idle_rec(4'd8);
    r.rw  = 1'b1;
    r.ret = 1'b1;
    step_any(r);
  endtask

  // Data access: mw wait cycles then ready; abandoned on timeout or by reset at rst_at.
  task automatic mem_access(input bit wr, input int mw, input int rst_at);
    rec_t r;
    for (int i = 0; i <= WaitMax; i++) begin
      if (i == rst_at) begin
        rst = 1'b0;
        step(idle_rec(wr ? 4'd5 : 4'd3), 1'b1);
        step(idle_rec(4'd0), 1'b1);
        rst = 1'b1;
        return;
      end
      r      = idle_rec(wr ? 4'd5 : 4'd3);
      r.mreq = 1'b1;
      r.mwr  = wr;
      r.adr  = 1'b1;
      if (i == mw) begin
        r.ret = wr;
        step(r, 1'b1);
        if (!wr) begin
          r      = idle_rec(4'd4);
          r.rsrc = 2'b01;
          r.rw   = 1'b1;
          r.ret  = 1'b1;
          step_any(r);
        end
        return;
      end
      r.berr = (i + 1 == WaitMax);
      step(r, 1'b0);
      if (r.berr) return;
    end
  endtask

  // Reference model for one whole instruction, fetch through completion.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input logic n, input int fw, input int mw, input int rst_at);
    rec_t r;
    op = o; func3 = f3; zero = z; neg = n;
    for (int i = 0; i <= fw; i++) begin
      r      = idle_rec(4'd0);
      r.mreq = 1'b1;
      r.asb  = 2'b10;
      r.rsrc = 2'b10;
      if (i == fw) begin
        r.irw = 1'b1;
        r.pcw = 1'b1;
        step(r, 1'b1);
      end else begin
        r.berr = ((i + 1) % WaitMax == 0);
        step(r, 1'b0);
      end
    end
    r     = idle_rec(4'd1);
    r.asa = 2'b01;
    r.asb = 2'b01;
    r.imm = (o == OpB) ? 3'd2 : (o == OpJal) ? 3'd3 : 3'd0;
    r.ill = !known_op(o);
    step_any(r);
    case (o)
      OpLw, OpS: begin
        r     = idle_rec(4'd2);
        r.asa = 2'b10;
        r.asb = 2'b01;
        r.imm = (o == OpS) ? 3'd1 : 3'd0;
        step_any(r);
        mem_access(o == OpS, mw, rst_at);
      end
      OpR: begin
        r     = idle_rec(4'd6);
        r.asa = 2'b10;
        r.aop = 2'b10;
        step_any(r);
        alu_wb();
      end
      OpI: begin
        r     = idle_rec(4'd7);
        r.asa = 2'b10;
        r.asb = 2'b01;
        r.aop = 2'b11;
        step_any(r);
        alu_wb();
      end
      OpB: begin
        r     = idle_rec(4'd9);
        r.asa = 2'b10;
        r.aop = 2'b01;
        r.pcw = branch_taken(f3, z, n);
        r.ret = 1'b1;
        step_any(r);
      end
      OpJalr, OpJal: begin
        if (o == OpJalr) begin
          r     = idle_rec(4'd10);
          r.asa = 2'b10;
          r.asb = 2'b01;
          step_any(r);
        end
        r     = idle_rec(4'd11);
        r.pcw = 1'b1;
        r.asa = 2'b01;
        r.asb = 2'b10;
        step_any(r);
        alu_wb();
      end
      OpLui: begin
        r      = idle_rec(4'd12);
        r.imm  = 3'd4;
        r.rsrc = 2'b11;
        r.rw   = 1'b1;
        r.ret  = 1'b1;
        step_any(r);
      end
      default: ;
    endcase
  endtask

  logic [6:0] op_tab [8];
  logic [6:0] rop;
  int         fw, mw;

  initial begin
    op_tab[0] = OpR;   op_tab[1] = OpI;   op_tab[2] = OpS;   op_tab[3] = OpB;
    op_tab[4] = OpLui; op_tab[5] = OpJal; op_tab[6] = OpLw;  op_tab[7] = OpJalr;

    rst = 1'b0; op = '0; func3 = '0; zero = 1'b0; neg = 1'b0; memReady = 1'b1;
    @(posedge clk);
    #1;
    // Reset held with the memory claiming ready: nothing may be strobed.
    repeat (2) step(idle_rec(4'd0), 1'b1);
    rst = 1'b1;

    run_instr(OpI, 3'd0, 1'b0, 1'b0, 0, 0, -1);           // addi
    run_instr(OpLw, 3'd2, 1'b0, 1'b0, 0, 2, -1);          // lw, two wait cycles
    foreach (op_tab[k]) run_instr(op_tab[k], 3'd0, 1'b1, 1'b0, 0, 0, -1);
    for (int f = 0; f < 5; f++) begin
      for (int zn = 0; zn < 4; zn++) begin
        run_instr(OpB, (f == 4) ? 3'd6 : 3'(f), zn[0], zn[1], 0, 0, -1);
      end
    end
    run_instr(OpJalr, 3'd0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, -1);     // illegal opcode
    run_instr(OpR, 3'd0, 1'b0, 1'b0, WaitMax, 0, -1);      // fetch timeout then retry
    run_instr(OpR, 3'd0, 1'b0, 1'b0, WaitMax - 1, 0, -1);  // ready on the timeout cycle
    run_instr(OpI, 3'd0, 1'b0, 1'b0, 2 * WaitMax + 1, 0, -1);
    run_instr(OpLw, 3'd2, 1'b0, 1'b0, 0, WaitMax, -1);     // load abandoned
    run_instr(OpS, 3'd2, 1'b0, 1'b0, 0, WaitMax - 1, -1);  // store completes at the limit
    run_instr(OpS, 3'd2, 1'b0, 1'b0, 0, WaitMax, -1);      // store abandoned
    run_instr(OpS, 3'd2, 1'b0, 1'b0, 0, 3, 1);             // reset mid-store
    run_instr(OpLw, 3'd2, 1'b0, 1'b0, 1, 2, 0);            // reset on first load cycle
    run_instr(OpLui, 3'd0, 1'b0, 1'b0, 0, 0, -1);

    for (int t = 0; t < 60; t++) begin
      rop = op_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) rop = 7'($urandom);
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 32) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), fw, mw,
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 2) : -1);
    end

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
